// File: rtl/pps_capture_pkg.sv
// rtl/pps_capture_pkg.sv - shared types, widths and status layout for the PPS capture block
package pps_capture_pkg;

    localparam int CNT_W   = 32;
    localparam int CTR_W   = 8;
    localparam int STATE_W = 3;

    localparam int ST_STATE_LSB = 29;
    localparam int ST_MISS_LSB  = 16;
    localparam int ST_BAD_LSB   = 8;
    localparam int ST_PULSE_LSB = 0;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ACQUIRE = 3'd1,
        ST_MEASURE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_LOST    = 3'd4
    } pps_state_e;

    function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pps_edge_sync.sv
// rtl/pps_edge_sync.sv - PPS pin synchroniser, rising-edge detect, optional deglitch (PPS_DEGLITCH_EN)
module pps_edge_sync
`ifdef PPS_DEGLITCH_EN
#(
    parameter int unsigned DEGLITCH_CYCLES = 4
)
`endif
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pps_i,
    output logic strobe_o
);

    logic sync1_q;
    logic sync2_q;
    logic fire;
    logic strobe_q;

    // Two-flop synchroniser for the asynchronous PPS pin
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pps_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef PPS_DEGLITCH_EN
    localparam int unsigned      RUN_W    = $clog2(DEGLITCH_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(DEGLITCH_CYCLES);
    localparam logic [RUN_W-1:0] RUN_FIRE = RUN_W'(DEGLITCH_CYCLES - 1);

    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;

    // Length of the current high run, saturating so a held pin fires only once
    always_comb begin
        run_d = '0;
        if (sync2_q) begin
            run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
        end
    end

    // Run-length register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

    assign fire = sync2_q && (run_q == RUN_FIRE);
`else
    logic prev_q;

    // Previous synchronised level for rising-edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sync2_q;
        end
    end

    assign fire = sync2_q && !prev_q;
`endif

    // Register the qualified edge so the strobe leaves this block glitch-free
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= fire;
        end
    end

    assign strobe_o = strobe_q;

endmodule

// File: rtl/pps_capture_ctrl.sv
// rtl/pps_capture_ctrl.sv - PPS period measurement and lock FSM top level (PPS_DEGLITCH_EN optional)
module pps_capture_ctrl
    import pps_capture_pkg::*;
#(
`ifdef PPS_DEGLITCH_EN
    parameter int unsigned DEGLITCH_CYCLES = 4,
`endif
    parameter int unsigned NOMINAL_PERIOD  = 256000000,
    parameter int unsigned TOLERANCE       = 16,
    parameter int unsigned MISS_LIMIT      = 3
) (
    input  logic        user_clk,
    input  logic        user_rst_n,
    input  logic        pps_raw,
    input  logic        arm,
    input  logic        clear,
    output logic        pps_strobe,
    output logic        locked,
    output logic [31:0] period_out,
    output logic [31:0] status_out
);

    localparam logic [CNT_W-1:0] WIN_LO      = (NOMINAL_PERIOD > TOLERANCE) ?
                                               CNT_W'(NOMINAL_PERIOD - TOLERANCE) : '0;
    localparam logic [CNT_W-1:0] WIN_HI      = CNT_W'(NOMINAL_PERIOD + TOLERANCE);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(NOMINAL_PERIOD + TOLERANCE + 1);

    logic             raw_strobe;
    logic             strobe_q, strobe_d;
    pps_state_e       state_q, state_d;
    logic             locked_q, locked_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CTR_W-1:0] pulse_q, pulse_d;
    logic [CTR_W-1:0] miss_q, miss_d;
    logic [CTR_W-1:0] bad_q, bad_d;
    logic [CTR_W-1:0] consec_q, consec_d;
    logic             in_win;
    logic             timeout;

    pps_edge_sync
`ifdef PPS_DEGLITCH_EN
    #(
        .DEGLITCH_CYCLES(DEGLITCH_CYCLES)
    )
`endif
    u_edge_sync (
        .clk_i    (user_clk),
        .rst_ni   (user_rst_n),
        .pps_i    (pps_raw),
        .strobe_o (raw_strobe)
    );

    assign in_win  = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
    assign timeout = (cnt_q == TIMEOUT_CNT) && !strobe_q;

    // Next-state for the lock FSM, period counter and event counters
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        pulse_d  = pulse_q;
        miss_d   = miss_q;
        bad_d    = bad_q;
        consec_d = consec_q;
        strobe_d = raw_strobe && arm && (state_q != ST_IDLE);

        if (!arm) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            consec_d = '0;
        end else begin
            if (state_q == ST_IDLE) begin
                cnt_d = '0;
            end else if (strobe_q || timeout) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end

            // The first strobe after acquisition has no preceding strobe to measure from
            if (strobe_q) begin
                pulse_d = pulse_q + 1'b1;
                if (state_q != ST_ACQUIRE) begin
                    period_d = cnt_q;
                end
            end

            case (state_q)
                ST_IDLE: state_d = ST_ACQUIRE;
                ST_ACQUIRE: begin
                    if (strobe_q) state_d = ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (strobe_q) begin
                        if (in_win) state_d = ST_LOCKED;
                        else        bad_d   = sat_inc(bad_q);
                    end else if (timeout) begin
                        state_d = ST_ACQUIRE;
                        miss_d  = sat_inc(miss_q);
                    end
                end
                ST_LOCKED: begin
                    if (strobe_q) begin
                        consec_d = '0;
                        if (!in_win) begin
                            state_d = ST_MEASURE;
                            bad_d   = sat_inc(bad_q);
                        end
                    end else if (timeout) begin
                        miss_d   = sat_inc(miss_q);
                        consec_d = consec_q + 1'b1;
                        if (({{(32-CTR_W){1'b0}}, consec_q} + 32'd1) >= MISS_LIMIT) begin
                            state_d = ST_LOST;
                        end
                    end
                end
                ST_LOST: begin
                    if (strobe_q) begin
                        state_d  = ST_MEASURE;
                        consec_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (clear) begin
            pulse_d = '0;
            miss_d  = '0;
            bad_d   = '0;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and counter registers; everything visible to software moves on the same edge
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            strobe_q <= 1'b0;
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
            cnt_q    <= '0;
            period_q <= '0;
            pulse_q  <= '0;
            miss_q   <= '0;
            bad_q    <= '0;
            consec_q <= '0;
        end else begin
            strobe_q <= strobe_d;
            state_q  <= state_d;
            locked_q <= locked_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            pulse_q  <= pulse_d;
            miss_q   <= miss_d;
            bad_q    <= bad_d;
            consec_q <= consec_d;
        end
    end

    // Pack the status word from registered fields
    always_comb begin
        status_out = '0;
        status_out[ST_STATE_LSB +: STATE_W] = state_q;
        status_out[ST_MISS_LSB  +: CTR_W]   = miss_q;
        status_out[ST_BAD_LSB   +: CTR_W]   = bad_q;
        status_out[ST_PULSE_LSB +: CTR_W]   = pulse_q;
    end

    assign pps_strobe = strobe_q;
    assign locked     = locked_q;
    assign period_out = period_q;

endmodule

// File: tb/tb_pps_capture_ctrl.sv
// tb/tb_pps_capture_ctrl.sv - directed self-checking bench for pps_capture_ctrl
module tb_pps_capture_ctrl;

    localparam int unsigned NOM  = 100;
    localparam int unsigned TOL  = 2;
    localparam int unsigned MISS = 3;
`ifdef PPS_DEGLITCH_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif

    logic        user_clk = 1'b0;
    logic        user_rst_n;
    logic        pps_raw;
    logic        arm;
    logic        clear;
    logic        pps_strobe;
    logic        locked;
    logic [31:0] period_out;
    logic [31:0] status_out;

    int nvec        = 0;
    int nerr        = 0;
    int cyc         = 0;
    int nstrobe     = 0;
    int last_strobe = -1;
    int pps_left    = 0;
    int n0;
    int t_to;

    always #5 user_clk = ~user_clk;

    pps_capture_ctrl #(
`ifdef PPS_DEGLITCH_EN
        .DEGLITCH_CYCLES(4),
`endif
        .NOMINAL_PERIOD(NOM),
        .TOLERANCE(TOL),
        .MISS_LIMIT(MISS)
    ) dut (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .pps_raw    (pps_raw),
        .arm        (arm),
        .clear      (clear),
        .pps_strobe (pps_strobe),
        .locked     (locked),
        .period_out (period_out),
        .status_out (status_out)
    );

    function automatic logic [31:0] st(input int s, input int m, input int b, input int p);
        return {s[2:0], 5'd0, m[7:0], b[7:0], p[7:0]};
    endfunction

    task automatic step();
        @(posedge user_clk);
        #1;
        cyc++;
        if (pps_strobe) begin
            nstrobe++;
            last_strobe = cyc;
        end
        if (pps_left > 0) begin
            pps_left--;
            if (pps_left == 0) pps_raw = 1'b0;
        end
    endtask

    task automatic go_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic pps_edge(input int e, input int w);
        go_to(e - 1);
        pps_raw  = 1'b1;
        pps_left = w;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        user_rst_n = 1'b0;
        pps_raw    = 1'b0;
        arm        = 1'b0;
        clear      = 1'b0;
        repeat (3) @(posedge user_clk);
        #1;
        chk("rst_strobe", {31'd0, pps_strobe}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_period", period_out, 32'd0);
        chk("rst_status", status_out, 32'd0);

        user_rst_n = 1'b1;
        cyc        = 0;
        arm        = 1'b1;

        pps_edge(10, 5);
        go_to(20);
        chk("first_strobe_cyc", last_strobe, 10 + LAT);
        chk("first_strobe_cnt", nstrobe, 1);
        chk("acq_to_measure", status_out, st(2, 0, 0, 1));

        pps_edge(110, 5);
        go_to(110 + LAT + 1);
        chk("second_strobe_cyc", last_strobe, 110 + LAT);
        chk("lock_period", period_out, 32'd100);
        chk("lock_locked", {31'd0, locked}, 32'd1);

        pps_edge(210, 5);
        go_to(210 + LAT + 1);
        chk("third_status", status_out, st(3, 0, 0, 3));
        chk("third_period", period_out, 32'd100);

        pps_edge(300, 5);
        go_to(300 + LAT + 1);
        chk("bad_status", status_out, st(2, 0, 1, 4));
        chk("bad_locked", {31'd0, locked}, 32'd0);
        chk("bad_period", period_out, 32'd90);

        pps_edge(400, 5);
        go_to(400 + LAT + 1);
        chk("relock_status", status_out, st(3, 0, 1, 5));

        go_to(503 + LAT);
        chk("pre_miss1", status_out, st(3, 0, 1, 5));
        step();
        chk("miss1", status_out, st(3, 1, 1, 5));
        go_to(606 + LAT);
        chk("pre_miss2", status_out, st(3, 1, 1, 5));
        step();
        chk("miss2", status_out, st(3, 2, 1, 5));
        go_to(710 + LAT);
        chk("miss3_lost", status_out, st(4, 3, 1, 5));
        chk("lost_locked", {31'd0, locked}, 32'd0);

        pps_edge(750, 5);
        go_to(750 + LAT + 1);
        chk("lost_to_measure", status_out, st(2, 3, 1, 6));

        t_to = 750 + LAT + 103;
        go_to(t_to);
        chk("pre_clear", status_out, st(2, 3, 1, 6));
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_vs_timeout", status_out, st(1, 0, 0, 0));

        pps_edge(900, 5);
        pps_edge(1000, 5);
        go_to(1050);
        chk("rearm_lock", status_out, st(3, 0, 0, 2));
        chk("rearm_period", period_out, 32'd100);
        arm = 1'b0;
        step();
        chk("disarm_idle", status_out, st(0, 0, 0, 2));
        chk("disarm_locked", {31'd0, locked}, 32'd0);

        n0 = nstrobe;
        pps_edge(1100, 5);
        go_to(1120);
        chk("idle_no_strobe", nstrobe, n0);
        chk("idle_hold_status", status_out, st(0, 0, 0, 2));
        chk("idle_hold_period", period_out, 32'd100);

        go_to(1130);
        arm = 1'b1;
        go_to(1132);
        chk("rearm_keeps_cnt", status_out, st(1, 0, 0, 2));

        n0 = nstrobe;
        pps_edge(1140, 200);
        go_to(1300);
        chk("held_one_strobe", nstrobe, n0 + 1);
        chk("held_status", status_out, st(1, 1, 0, 3));

        go_to(1350);
        #2;
        user_rst_n = 1'b0;
        #1;
        chk("mid_rst_strobe", {31'd0, pps_strobe}, 32'd0);
        chk("mid_rst_locked", {31'd0, locked}, 32'd0);
        chk("mid_rst_period", period_out, 32'd0);
        chk("mid_rst_status", status_out, 32'd0);
        @(posedge user_clk);
        #1;
        user_rst_n = 1'b1;
        cyc        = 0;

        n0 = nstrobe;
`ifdef PPS_DEGLITCH_EN
        pps_edge(10, 3);
        go_to(30);
        chk("glitch3_ignored", nstrobe, n0);
        pps_edge(40, 4);
        go_to(60);
        chk("pulse4_strobe_cnt", nstrobe, n0 + 1);
        chk("pulse4_strobe_cyc", last_strobe, 46);
`else
        pps_edge(10, 1);
        go_to(30);
        chk("pulse1_strobe_cnt", nstrobe, n0 + 1);
        chk("pulse1_strobe_cyc", last_strobe, 13);
`endif
        chk("post_rst_status", status_out, st(2, 0, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pps_capture_ctrl.md
# pps_capture_ctrl

Sequencer and monitor for the raw PPS input feeding the `adc_in_raw_pps` software register. It synchronises the asynchronous PPS pin into `user_clk` and measures each PPS period in clock cycles. A small lock state machine tracks missing and out-of-window pulses. Two 32-bit words, period and status, drive the `user_data_in` ports of the simulink2ppc registers.

## Interface
- `NOMINAL_PERIOD`, default 256000000: expected `user_clk` cycles per PPS.
- `TOLERANCE`, default 16: allowed |period − NOMINAL_PERIOD|.
- `MISS_LIMIT`, default 3: consecutive missed pulses before LOST.
- `DEGLITCH_CYCLES`, default 4: used only with `PPS_DEGLITCH_EN`.
- `user_clk`  in  1  sole clock.
- `user_rst_n`  in  1  asynchronous, active-low reset.
- `pps_raw`  in  1  asynchronous PPS pin.
- `arm`  in  1  level; 0 forces IDLE.
- `clear`  in  1  one-cycle pulse; zeroes counters.
- `pps_strobe`  out  1  one-cycle pulse per accepted PPS edge.
- `locked`  out  1  high in LOCKED.
- `period_out`  out  32  last measured period.
- `status_out`  out  32  bits [31:29] state code, [28:24] 0, [23:16] miss_cnt, [15:8] bad_cnt, [7:0] pulse_cnt.

## Operation
- `pps_raw` passes through a 2-flop synchroniser, then a rising-edge detect. An edge becomes a strobe whenever the block is not in IDLE.
- `cnt`, 32 bits: set to 1 on a strobe or timeout, otherwise incremented, saturating at 2^32−1. At a strobe, `period_out` loads `cnt`, so the value equals the cycles between consecutive strobes.
- In window: NOMINAL−TOL ≤ cnt ≤ NOMINAL+TOL. Timeout: `cnt` == NOMINAL+TOL+1 with no strobe.
- State codes: IDLE=0, ACQUIRE=1, MEASURE=2, LOCKED=3, LOST=4.
- From any state, `arm`=0 → IDLE on the next cycle.
- IDLE with `arm` → ACQUIRE.
- ACQUIRE with strobe → MEASURE. ACQUIRE does not time out.
- MEASURE:
  - strobe in window → LOCKED.
  - strobe out of window → stay in MEASURE, bad_cnt++.
  - timeout → ACQUIRE, miss_cnt++.
- LOCKED:
  - strobe in window → stay, consec cleared.
  - strobe out of window → MEASURE, bad_cnt++, consec cleared.
  - timeout → miss_cnt++, consec++; when consec reaches MISS_LIMIT → LOST, otherwise stay.
- LOST with strobe → MEASURE, consec cleared.
- Counters:
  - pulse_cnt is 8 bits and wraps; it counts strobes.
  - miss_cnt and bad_cnt are 8 bits and saturate at 255.
  - `clear` zeroes all three counters and does not change state. If `clear` coincides with an increment, `clear` wins.
- Counters and `period_out` hold their values in IDLE. Re-arming does not clear them.

## Timing
- Reset values: all outputs 0, state IDLE, `cnt` 0, consec 0.
- Latency from a `pps_raw` rising edge (sampled) to `pps_strobe` is 3 cycles.
- `period_out`, the counters, state and `locked` all update together, 1 cycle after `pps_strobe`. They are registered and glitch-free for the register crossing.
- If a strobe and a timeout fall in the same cycle, the strobe wins.
- Reset asserted mid-period returns the block to the reset values immediately. A partial period is never reported.
- `pps_raw` held high produces exactly one strobe.

## Configuration
- `PPS_DEGLITCH_EN` defined:
  - The synchronised PPS must stay high for DEGLITCH_CYCLES consecutive cycles.
  - The strobe fires in the cycle the run reaches DEGLITCH_CYCLES, so latency is 3+DEGLITCH_CYCLES−1.
  - Shorter pulses are ignored.
- `PPS_DEGLITCH_EN` undefined: strobe on the bare synchronised rising edge. The run counter is not built.

## Structure
- Shared package `pps_capture_pkg`:
  - state enum with the codes above.
  - status field bit positions.
  - counter widths.
- One sub-module, `pps_edge_sync`, holds the synchroniser, edge detect and optional deglitch, and outputs the raw strobe. The FSM, counters and output packing stay in the top level.

## Test plan
- Tests use NOMINAL_PERIOD=100, TOLERANCE=2, MISS_LIMIT=3.
- Arm, then send PPS edges at cycles 10, 110 and 210 → strobes at 13, 113 and 213. `period_out`=100 after the second strobe, state LOCKED, pulse_cnt=3.
- While LOCKED, send an edge 90 cycles after the previous one → bad_cnt=1, state MEASURE, `locked`=0, `period_out`=90.
- While LOCKED, stop PPS → miss_cnt steps to 1, 2, 3 at 103-cycle intervals, then state LOST. The next edge → MEASURE.
- Pulse `clear` in the same cycle as a timeout → miss_cnt reads 0.
- Deassert `arm` mid-period → IDLE next cycle. Further edges produce no strobe and no counter change.
- With `PPS_DEGLITCH_EN` and DEGLITCH_CYCLES=4: a 3-cycle high pulse gives no strobe. A 4-cycle pulse gives a strobe 6 cycles after its edge.
